// File: rtl/red_pitaya_pwm_ramp.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_pwm_ramp
//  Purpose  : Slew-rate-limited sequencer for the four PWM DAC channels.
//             Each channel ramps toward a software target. A prescaler tick
//             starts a round-robin pass that moves one channel per clock by
//             at most one step. The result is clamped to the target.
//  Options  : PWM_RAMP_IRQ_EN - adds irq_o and the interrupt-enable
//             register at 0x1C
//  Revision : 1.0 - initial release
// ============================================================================
module red_pitaya_pwm_ramp #(
    parameter int DW        = 14,
    parameter int PW        = 24,
    parameter int PRESC_RST = 124
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [DW-1:0] pwm0_o,
    output logic [DW-1:0] pwm1_o,
    output logic [DW-1:0] pwm2_o,
    output logic [DW-1:0] pwm3_o,
`ifdef PWM_RAMP_IRQ_EN
    output logic          irq_o,
`endif
    output logic          busy_o,
    input  logic [31:0]   sys_addr,
    input  logic [31:0]   sys_wdata,
    input  logic [3:0]    sys_sel,
    input  logic          sys_wen,
    input  logic          sys_ren,
    output logic [31:0]   sys_rdata,
    output logic          sys_err,
    output logic          sys_ack
);

    // Register offsets within the 20-bit decoded window
    localparam logic [19:0] c_ADDR_TGT0   = 20'h00000;
    localparam logic [19:0] c_ADDR_TGT1   = 20'h00004;
    localparam logic [19:0] c_ADDR_TGT2   = 20'h00008;
    localparam logic [19:0] c_ADDR_TGT3   = 20'h0000C;
    localparam logic [19:0] c_ADDR_STEP   = 20'h00010;
    localparam logic [19:0] c_ADDR_PRESC  = 20'h00014;
    localparam logic [19:0] c_ADDR_STATUS = 20'h00018;
`ifdef PWM_RAMP_IRQ_EN
    localparam logic [19:0] c_ADDR_IRQEN  = 20'h0001C;
`endif
    localparam logic [19:0] c_ADDR_CUR0   = 20'h00020;
    localparam logic [19:0] c_ADDR_CUR1   = 20'h00024;
    localparam logic [19:0] c_ADDR_CUR2   = 20'h00028;
    localparam logic [19:0] c_ADDR_CUR3   = 20'h0002C;

    // Scheduler states
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_UPD0 = 3'd1;
    localparam logic [2:0] c_ST_UPD1 = 3'd2;
    localparam logic [2:0] c_ST_UPD2 = 3'd3;
    localparam logic [2:0] c_ST_UPD3 = 3'd4;

    // Intermediate width: two extra bits hold cur +/- a full-range unsigned
    // step without overflow, so the clamp compare is always exact.
    localparam int c_XW = DW + 2;

    // Smallest usable prescaler: keeps the tick period longer than a pass
    localparam logic [PW-1:0] c_PRESC_MIN = PW'(4);

    logic [19:0]     w_addr;
    logic            w_wr_step;
    logic            w_wr_presc;

    logic [DW-1:0]   r_tgt [4];
    logic [DW-1:0]   r_cur [4];
    logic [DW-1:0]   r_step;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   r_cnt;
    logic [PW-1:0]   w_presc_eff;
    logic            w_tick;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic            w_upd_en;
    logic [1:0]      w_upd_idx;

    logic [DW-1:0]   w_sel_cur;
    logic [DW-1:0]   w_sel_tgt;
    logic signed [c_XW-1:0] w_cur_x;
    logic signed [c_XW-1:0] w_tgt_x;
    logic signed [c_XW-1:0] w_step_x;
    logic signed [c_XW-1:0] w_sum;
    logic signed [c_XW-1:0] w_dif;
    logic [DW-1:0]   w_upd_val;

    logic [3:0]      w_ch_busy;
    logic            w_any_busy;
    logic            r_busy;
    logic            r_ack;
    logic [31:0]     r_rdata;
    logic [31:0]     w_rdata;
    logic            w_unused;

`ifdef PWM_RAMP_IRQ_EN
    logic            r_irq_en;
    logic            r_irq;
`endif

    // Only the low address bits and partial data fields are used; byte
    // selects are ignored because only full-word writes are supported.
    assign w_unused   = ^{sys_sel, sys_addr, sys_wdata};

    assign w_addr     = sys_addr[19:0];
    assign w_wr_step  = sys_wen && (w_addr == c_ADDR_STEP);
    assign w_wr_presc = sys_wen && (w_addr == c_ADDR_PRESC);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    assign w_presc_eff = (r_presc < c_PRESC_MIN) ? c_PRESC_MIN : r_presc;
    // >= rather than == so a prescaler lowered below the count wraps at once
    assign w_tick      = (r_cnt >= w_presc_eff);

    // Tick counter: counts 0..presc_eff, cleared by a prescaler write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_wr_presc || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a tick starts one pass over the four channels
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_tick) w_state_nxt = c_ST_UPD0;
            c_ST_UPD0: w_state_nxt = c_ST_UPD1;
            c_ST_UPD1: w_state_nxt = c_ST_UPD2;
            c_ST_UPD2: w_state_nxt = c_ST_UPD3;
            c_ST_UPD3: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs: which channel (if any) is updated this cycle
    always_comb begin
        w_upd_en  = 1'b0;
        w_upd_idx = 2'd0;
        case (r_state)
            c_ST_UPD0: begin w_upd_en = 1'b1; w_upd_idx = 2'd0; end
            c_ST_UPD1: begin w_upd_en = 1'b1; w_upd_idx = 2'd1; end
            c_ST_UPD2: begin w_upd_en = 1'b1; w_upd_idx = 2'd2; end
            c_ST_UPD3: begin w_upd_en = 1'b1; w_upd_idx = 2'd3; end
            default:   begin w_upd_en = 1'b0; w_upd_idx = 2'd0; end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared step datapath for the channel being visited
    // ------------------------------------------------------------------
    assign w_sel_cur = r_cur[w_upd_idx];
    assign w_sel_tgt = r_tgt[w_upd_idx];
    assign w_cur_x   = {{2{w_sel_cur[DW-1]}}, w_sel_cur};
    assign w_tgt_x   = {{2{w_sel_tgt[DW-1]}}, w_sel_tgt};
    assign w_step_x  = {2'b00, r_step};
    assign w_sum     = w_cur_x + w_step_x;
    assign w_dif     = w_cur_x - w_step_x;

    // Move one step toward the target, clamping so it never overshoots
    always_comb begin
        w_upd_val = w_sel_cur;
        if (w_cur_x < w_tgt_x) begin
            w_upd_val = (w_sum > w_tgt_x) ? w_sel_tgt : w_sum[DW-1:0];
        end else if (w_cur_x > w_tgt_x) begin
            w_upd_val = (w_dif < w_tgt_x) ? w_sel_tgt : w_dif[DW-1:0];
        end
    end

    // Current values: only the visited channel changes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) r_cur[i] <= '0;
        end else if (w_upd_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_upd_idx == 2'(i)) r_cur[i] <= w_upd_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Software registers
    // ------------------------------------------------------------------
    // Targets: a write coinciding with that channel's update lands after it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) r_tgt[i] <= '0;
        end else if (sys_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (w_addr == c_ADDR_TGT0 + 20'(4 * i)) r_tgt[i] <= sys_wdata[DW-1:0];
            end
        end
    end

    // Step and prescaler configuration
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_step  <= DW'(1);
            r_presc <= PW'(PRESC_RST);
        end else begin
            if (w_wr_step)  r_step  <= sys_wdata[DW-1:0];
            if (w_wr_presc) r_presc <= sys_wdata[PW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Busy / interrupt
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 4; g++) begin : g_ch_busy
        assign w_ch_busy[g] = (r_cur[g] != r_tgt[g]);
    end

    assign w_any_busy = |w_ch_busy;

    // Registered busy: lags the final update by one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= w_any_busy;
        end
    end

`ifdef PWM_RAMP_IRQ_EN
    // Interrupt enable and a single pulse aligned with the busy fall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (sys_wen && (w_addr == c_ADDR_IRQEN)) r_irq_en <= sys_wdata[0];
            r_irq <= r_irq_en && r_busy && !w_any_busy;
        end
    end

    assign irq_o = r_irq;
`endif

    // ------------------------------------------------------------------
    // Bus read path
    // ------------------------------------------------------------------
    function automatic logic [31:0] f_sext(input logic [DW-1:0] v);
        return {{(32-DW){v[DW-1]}}, v};
    endfunction

    // Read mux; unmapped offsets return zero
    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            c_ADDR_TGT0:   w_rdata = f_sext(r_tgt[0]);
            c_ADDR_TGT1:   w_rdata = f_sext(r_tgt[1]);
            c_ADDR_TGT2:   w_rdata = f_sext(r_tgt[2]);
            c_ADDR_TGT3:   w_rdata = f_sext(r_tgt[3]);
            c_ADDR_STEP:   w_rdata = {{(32-DW){1'b0}}, r_step};
            c_ADDR_PRESC:  w_rdata = 32'(r_presc);
            c_ADDR_STATUS: w_rdata = {27'd0, r_busy, w_ch_busy};
`ifdef PWM_RAMP_IRQ_EN
            c_ADDR_IRQEN:  w_rdata = {31'd0, r_irq_en};
`endif
            c_ADDR_CUR0:   w_rdata = f_sext(r_cur[0]);
            c_ADDR_CUR1:   w_rdata = f_sext(r_cur[1]);
            c_ADDR_CUR2:   w_rdata = f_sext(r_cur[2]);
            c_ADDR_CUR3:   w_rdata = f_sext(r_cur[3]);
            default:       w_rdata = 32'd0;
        endcase
    end

    // Acknowledge one cycle after any request; read data valid with it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack <= sys_wen | sys_ren;
            if (sys_ren) r_rdata <= w_rdata;
        end
    end

    assign sys_ack   = r_ack;
    assign sys_rdata = r_rdata;
    assign sys_err   = 1'b0;
    assign busy_o    = r_busy;
    assign pwm0_o    = r_cur[0];
    assign pwm1_o    = r_cur[1];
    assign pwm2_o    = r_cur[2];
    assign pwm3_o    = r_cur[3];

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_pwm_ramp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_red_pitaya_pwm_ramp
//  Purpose  : Directed self-checking bench for red_pitaya_pwm_ramp
//  Revision : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_pwm_ramp;

    localparam int DW = 14;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic signed [DW-1:0] pwm0, pwm1, pwm2, pwm3;
    logic                 busy;
    logic [31:0]          sys_addr, sys_wdata, sys_rdata;
    logic [3:0]           sys_sel;
    logic                 sys_wen, sys_ren, sys_err, sys_ack;
`ifdef PWM_RAMP_IRQ_EN
    logic                 irq;
`endif

    int checks = 0;
    int errors = 0;

    red_pitaya_pwm_ramp #(.DW(DW), .PW(24), .PRESC_RST(124)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .pwm0_o    (pwm0),
        .pwm1_o    (pwm1),
        .pwm2_o    (pwm2),
        .pwm3_o    (pwm3),
`ifdef PWM_RAMP_IRQ_EN
        .irq_o     (irq),
`endif
        .busy_o    (busy),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_sel   (sys_sel),
        .sys_wen   (sys_wen),
        .sys_ren   (sys_ren),
        .sys_rdata (sys_rdata),
        .sys_err   (sys_err),
        .sys_ack   (sys_ack)
    );

    always #4 clk_i = ~clk_i;

    // Advance one clock; sample point is 1 ns after the rising edge
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sys_addr  = a;
        sys_wdata = d;
        sys_wen   = 1'b1;
        cyc();
        sys_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sys_addr = a;
        sys_ren  = 1'b1;
        cyc();
        sys_ren  = 1'b0;
        d        = sys_rdata;
    endtask

    function automatic int get_pwm(input int ch);
        case (ch)
            0:       return int'(pwm0);
            1:       return int'(pwm1);
            2:       return int'(pwm2);
            default: return int'(pwm3);
        endcase
    endfunction

    // Wait (bounded) for a channel output to change
    task automatic wait_change(input int ch, output int val, output int n);
        int prev;
        prev = get_pwm(ch);
        n = 0;
        while (get_pwm(ch) == prev && n < 300) begin
            cyc();
            n++;
        end
        val = get_pwm(ch);
        if (val == prev) begin
            checks++;
            errors++;
            $display("FAIL wait_change ch%0d: stuck at %0d, expected a change", ch, val);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc(); cyc(); cyc();
        rst_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (get_pwm(c) !== 0) begin
                errors++; $display("FAIL reset_pwm%0d: got %0d expected 0", c, get_pwm(c));
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (sys_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", sys_ack); end
        checks++;
        if (sys_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", sys_rdata); end
        checks++;
        if (sys_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", sys_err); end
`ifdef PWM_RAMP_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
`endif
        bus_read(32'h10, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL reset_step: got %0d expected 1", d); end
        bus_read(32'h14, d);
        checks++;
        if (d !== 32'd124) begin errors++; $display("FAIL reset_presc: got %0d expected 124", d); end
    endtask

    task automatic test_bus_timing();
        sys_addr = 32'h14;
        sys_ren  = 1'b1;
        cyc();
        sys_ren  = 1'b0;
        checks++;
        if (sys_ack !== 1'b1) begin errors++; $display("FAIL ack_rise: got %b expected 1", sys_ack); end
        checks++;
        if (sys_rdata !== 32'd124) begin errors++; $display("FAIL ack_rdata: got %0d expected 124", sys_rdata); end
        cyc();
        checks++;
        if (sys_ack !== 1'b0) begin errors++; $display("FAIL ack_fall: got %b expected 0", sys_ack); end
    endtask

    task automatic test_ramp_up();
        int exp_v[7] = '{16, 32, 48, 64, 80, 96, 100};
        int v, n;
        bus_write(32'h14, 32'd9);
        bus_write(32'h10, 32'd16);
        bus_write(32'h00, 32'd100);
        for (int k = 0; k < 7; k++) begin
            wait_change(0, v, n);
            checks++;
            if (v !== exp_v[k]) begin errors++; $display("FAIL ramp_val%0d: got %0d expected %0d", k, v, exp_v[k]); end
            if (k > 0) begin
                checks++;
                if (n !== 10) begin errors++; $display("FAIL ramp_period%0d: got %0d expected 10", k, n); end
            end
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy_hold: got %b expected 1", busy); end
        cyc();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_fall: got %b expected 0", busy); end
        for (int c = 1; c < 4; c++) begin
            checks++;
            if (get_pwm(c) !== 0) begin errors++; $display("FAIL ramp_other%0d: got %0d expected 0", c, get_pwm(c)); end
        end
    endtask

    task automatic test_negative_clamp();
        logic [31:0] d;
        int v, n, e;
        do_reset();
        bus_write(32'h10, 32'd0);
        for (int c = 0; c < 4; c++) bus_write(32'(4 * c), 32'hFFFF_E000);
        bus_write(32'h14, 32'd4);
        bus_write(32'h10, 32'd8191);
        wait_change(0, v, n);
        // ch c: 0 before its slot, -8191 for one pass, then -8192
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 4; c++) begin
                e = (k < c) ? 0 : (k < c + 5) ? -8191 : -8192;
                checks++;
                if (get_pwm(c) !== e) begin
                    errors++; $display("FAIL neg_k%0d_ch%0d: got %0d expected %0d", k, c, get_pwm(c), e);
                end
            end
            if (k == 9) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL neg_busy: got %b expected 0", busy); end
            end
            cyc();
        end
        repeat (20) cyc();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (get_pwm(c) !== -8192) begin errors++; $display("FAIL neg_hold%0d: got %0d expected -8192", c, get_pwm(c)); end
        end
        bus_read(32'h00, d);
        checks++;
        if (d !== 32'hFFFF_E000) begin errors++; $display("FAIL rd_tgt0: got %h expected ffffe000", d); end
        bus_read(32'h2C, d);
        checks++;
        if (d !== 32'hFFFF_E000) begin errors++; $display("FAIL rd_cur3: got %h expected ffffe000", d); end
        bus_read(32'h18, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL rd_status: got %h expected 0", d); end
        bus_read(32'h30, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL rd_unmapped: got %h expected 0", d); end
    endtask

    task automatic test_retarget();
        logic [31:0] d;
        int v, n, it;
        do_reset();
        bus_write(32'h14, 32'd9);
        bus_write(32'h10, 32'd100);
        bus_write(32'h04, 32'd1000);
        v = 0; it = 0;
        while (v != 400 && it < 8) begin
            wait_change(1, v, n);
            it++;
        end
        checks++;
        if (v !== 400) begin errors++; $display("FAIL retarget_reach: got %0d expected 400", v); end
        bus_read(32'h18, d);
        checks++;
        if (d !== 32'h12) begin errors++; $display("FAIL retarget_status: got %h expected 12", d); end
        bus_write(32'h04, 32'd200);
        wait_change(1, v, n);
        checks++;
        if (v !== 300) begin errors++; $display("FAIL retarget_first: got %0d expected 300", v); end
        wait_change(1, v, n);
        checks++;
        if (v !== 200) begin errors++; $display("FAIL retarget_second: got %0d expected 200", v); end
        repeat (25) cyc();
        checks++;
        if (pwm1 !== 14'sd200) begin errors++; $display("FAIL retarget_hold: got %0d expected 200", pwm1); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL retarget_busy: got %b expected 0", busy); end
    endtask

    task automatic test_step_freeze();
        int v, n;
        bit moved;
        bus_write(32'h04, 32'hFFFF_FC18);
        wait_change(1, v, n);
        checks++;
        if (v !== 100) begin errors++; $display("FAIL freeze_pre: got %0d expected 100", v); end
        bus_write(32'h10, 32'd0);
        moved = 1'b0;
        for (int k = 0; k < 35; k++) begin
            cyc();
            if (pwm1 !== 14'sd100) moved = 1'b1;
        end
        checks++;
        if (moved) begin errors++; $display("FAIL freeze_hold: got %0d expected 100 throughout", pwm1); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL freeze_busy: got %b expected 1", busy); end
        bus_write(32'h10, 32'd50);
        wait_change(1, v, n);
        checks++;
        if (v !== 50) begin errors++; $display("FAIL resume_first: got %0d expected 50", v); end
        wait_change(1, v, n);
        checks++;
        if (v !== 0) begin errors++; $display("FAIL resume_second: got %0d expected 0", v); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int v, n, it;
        do_reset();
        bus_write(32'h14, 32'd9);
        bus_write(32'h10, 32'd100);
        bus_write(32'h08, 32'd500);
        v = 0; it = 0;
        while (v != 300 && it < 6) begin
            wait_change(2, v, n);
            it++;
        end
        checks++;
        if (v !== 300) begin errors++; $display("FAIL areset_reach: got %0d expected 300", v); end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (pwm2 !== 14'sd0) begin errors++; $display("FAIL areset_pwm2: got %0d expected 0", pwm2); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        #1;
        rst_i = 1'b0;
        cyc();
        checks++;
        if (pwm2 !== 14'sd0) begin errors++; $display("FAIL areset_after: got %0d expected 0", pwm2); end
        bus_read(32'h10, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL areset_step: got %0d expected 1", d); end
        bus_read(32'h08, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL areset_tgt2: got %0d expected 0", d); end
        bus_read(32'h14, d);
        checks++;
        if (d !== 32'd124) begin errors++; $display("FAIL areset_presc: got %0d expected 124", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
`ifdef PWM_RAMP_IRQ_EN
        int v, n;
        bus_write(32'h1C, 32'd1);
        bus_read(32'h1C, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL irq_en_rd: got %0d expected 1", d); end
        bus_write(32'h14, 32'd4);
        bus_write(32'h10, 32'd1000);
        bus_write(32'h00, 32'd1500);
        wait_change(0, v, n);
        wait_change(0, v, n);
        checks++;
        if (v !== 1500) begin errors++; $display("FAIL irq_final: got %0d expected 1500", v); end
        checks++;
        if (irq !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL irq_before: got irq=%b busy=%b expected irq=0 busy=1", irq, busy);
        end
        cyc();
        checks++;
        if (irq !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL irq_pulse: got irq=%b busy=%b expected irq=1 busy=0", irq, busy);
        end
        cyc();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_width: got %b expected 0", irq); end
`else
        bus_write(32'h1C, 32'd1);
        bus_read(32'h1C, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL irq_reg_absent: got %0d expected 0", d); end
`endif
    endtask

    initial begin
        rst_i     = 1'b1;
        sys_addr  = 32'd0;
        sys_wdata = 32'd0;
        sys_sel   = 4'hF;
        sys_wen   = 1'b0;
        sys_ren   = 1'b0;
        test_reset();
        test_bus_timing();
        test_ramp_up();
        test_negative_clamp();
        test_retarget();
        test_step_freeze();
        test_async_reset();
        test_irq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a wait loop is ever broken
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
